dla_axi_rd_master: RTL and testbench

- AXI4 read master (burst initiator) that lets the DLA fetch ifmap/weight words from system memory.
- It is the counterpart to the DLA's existing AXI4 slave port.
- Accepts a (start address, word count) command, splits it into INCR bursts of at most 16 beats that never cross a 4 KB boundary, and streams the returned words out on a valid/ready interface.
- Sits between the DLA core and one master port of the AXI interconnect, in the DLA clock domain.

---
 rtl/dla_axi_rd_master.sv | 157 +++++++++++++++
 tb/tb_dla_axi_rd_master.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dla_axi_rd_master.sv
// AXI4 read master for DLA ifmap/weight fetch: splits (address, word count) commands
// into INCR bursts of at most MAX_BEATS beats that never cross a 4 KB page.
module dla_axi_rd_master #(
  parameter logic [7:0] MST_ID    = 8'h02,
  parameter int         MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [15:0] cmd_words,
  output logic [7:0]  ARID,
  output logic [31:0] ARADDR,
  output logic [3:0]  ARLEN,
  output logic [2:0]  ARSIZE,
  output logic [1:0]  ARBURST,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [7:0]  RID,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RLAST,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

  localparam logic [16:0] LP_MAX_BEATS = 17'(MAX_BEATS);

  state_t      r_state;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [4:0]  r_beat_cnt;
  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [3:0]  r_arlen;
  logic        r_done;
  logic        r_err;

  logic        w_in_r;
  logic        w_beat;
  logic        w_last_beat;
  logic        w_beat_err;
  logic [31:0] w_cmd_addr;
  logic [4:0]  w_cmd_beats;
  logic [31:0] w_addr_nxt;
  logic [15:0] w_rem_nxt;
  logic [4:0]  w_nxt_beats;
  logic        w_unused;

  // Beats for the next burst: bounded by words left, burst cap and words left in the 4 KB page.
  function automatic logic [4:0] f_beats(input logic [9:0] word_idx, input logic [15:0] rem);
    logic [16:0] room;
    logic [16:0] n;
    room = 17'd1024 - {7'd0, word_idx};
    n    = {1'b0, rem};
    if (n > LP_MAX_BEATS) n = LP_MAX_BEATS;
    if (n > room) n = room;
    return 5'(n);
  endfunction

  assign w_in_r      = (r_state == S_R);
  assign w_beat      = w_in_r && RVALID && out_ready;
  assign w_last_beat = (r_beat_cnt == 5'd1);
  assign w_beat_err  = (RRESP != 2'b00) || (RID != MST_ID) || (RLAST != w_last_beat);

  assign w_cmd_addr  = {cmd_addr[31:2], 2'b00};
  assign w_cmd_beats = f_beats(cmd_addr[11:2], cmd_words);
  assign w_addr_nxt  = r_addr + 32'd4;
  assign w_rem_nxt   = r_remaining - 16'd1;
  assign w_nxt_beats = f_beats(w_addr_nxt[11:2], w_rem_nxt);
  assign w_unused    = ^cmd_addr[1:0];

  assign cmd_ready = (r_state == S_IDLE);
  assign ARID      = MST_ID;
  assign ARADDR    = r_araddr;
  assign ARLEN     = r_arlen;
  assign ARSIZE    = 3'b010;
  assign ARBURST   = 2'b01;
  assign ARVALID   = r_arvalid;
  assign RREADY    = w_in_r ? out_ready : 1'b0;
  assign out_valid = w_in_r ? RVALID : 1'b0;
  assign out_data  = w_in_r ? RDATA : 32'd0;
  assign done      = r_done;
  assign err       = r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_remaining <= 16'd0;
      r_beat_cnt  <= 5'd0;
      r_arvalid   <= 1'b0;
      r_araddr    <= 32'd0;
      r_arlen     <= 4'd0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr      <= w_cmd_addr;
            r_remaining <= cmd_words;
            r_err       <= 1'b0;
            if (cmd_words == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_AR;
              r_arvalid <= 1'b1;
              r_araddr  <= w_cmd_addr;
              r_arlen   <= 4'(w_cmd_beats - 5'd1);
            end
          end
        end
        S_AR: begin
          if (ARREADY) begin
            r_arvalid  <= 1'b0;
            r_beat_cnt <= {1'b0, r_arlen} + 5'd1;
            r_state    <= S_R;
          end
        end
        S_R: begin
          if (w_beat) begin
            r_beat_cnt  <= r_beat_cnt - 5'd1;
            r_remaining <= w_rem_nxt;
            r_addr      <= w_addr_nxt;
            if (w_beat_err) r_err <= 1'b1;
            // The burst ends on the counted beat regardless of what RLAST claims.
            if (w_last_beat) begin
              if (w_rem_nxt != 16'd0) begin
                r_state   <= S_AR;
                r_arvalid <= 1'b1;
                r_araddr  <= w_addr_nxt;
                r_arlen   <= 4'(w_nxt_beats - 5'd1);
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dla_axi_rd_master.sv
// Bench for dla_axi_rd_master: table of directed commands, random commands and a reset
// sequence, all checked against a burst/word model and an AXI slave model.
module tb_dla_axi_rd_master;

  localparam logic [7:0] MST_ID = 8'h02;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_words;
  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  dla_axi_rd_master #(.MST_ID(MST_ID), .MAX_BEATS(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_words(cmd_words),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .err(err)
  );

  typedef struct {
    logic [31:0] addr;
    logic [15:0] words;
    int          resp_bad;
    int          last_bad;
    int          id_bad;
    int          ar_delay;
    int          ready_pct;
    int          gap_pct;
    int          exp_nb;
    logic        exp_err;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave / environment state
  logic [31:0] q_addr[$];
  logic [3:0]  q_len[$];
  logic [31:0] ar_log_addr[$];
  logic [3:0]  ar_log_len[$];
  logic [31:0] got[$];
  int          r_beat, cmd_beat, ar_wait;
  int          ar_delay, ready_pct, gap_pct, resp_bad, last_bad, id_bad;
  logic [31:0] data_base, data_xor;
  logic        r_taken, hold_v;
  logic [31:0] hold_addr;
  logic [3:0]  hold_len;
  int          cyc, done_cnt, done_cyc, acc_cyc, first_ar_cyc;
  logic        done_err;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [15:0] pend_words;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input int w, input int rb, input int lb,
                              input int ib, input int ad, input int rp, input int gp,
                              input int nb, input logic e);
    vec_t v;
    v.addr = a; v.words = 16'(w); v.resp_bad = rb; v.last_bad = lb; v.id_bad = ib;
    v.ar_delay = ad; v.ready_pct = rp; v.gap_pct = gp; v.exp_nb = nb; v.exp_err = e;
    return v;
  endfunction

  task automatic clear_slave();
    q_addr.delete(); q_len.delete();
    r_beat = 0; r_taken = 1'b0; hold_v = 1'b0; ar_wait = 0;
    RVALID = 1'b0; ARREADY = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = MST_ID; RDATA = 32'd0;
  endtask

  // One clock: drive everything at the falling edge, then look at what the rising edge will take.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    cmd_valid = pend_valid; cmd_addr = pend_addr; cmd_words = pend_words;
    ARREADY = ARVALID && (ar_wait >= ar_delay);
    if (r_taken) RVALID = 1'b0;
    r_taken = 1'b0;
    if (!RVALID && q_addr.size() > 0 && int'($urandom_range(99)) >= gap_pct) begin
      RVALID = 1'b1;
      RDATA  = (((q_addr[0] + 32'(4 * r_beat)) - data_base) >> 2) ^ data_xor;
      RLAST  = (r_beat == int'(q_len[0])) ^ (cmd_beat == last_bad);
      RRESP  = (cmd_beat == resp_bad) ? 2'b10 : 2'b00;
      RID    = (cmd_beat == id_bad) ? 8'h05 : MST_ID;
    end
    out_ready = (int'($urandom_range(99)) < ready_pct);
    #1;
    if (ARVALID) begin
      if (first_ar_cyc < 0) first_ar_cyc = cyc;
      if (hold_v) begin
        check("ar_stable_addr", ARADDR, hold_addr);
        check("ar_stable_len", 32'(ARLEN), 32'(hold_len));
      end
      hold_v = !ARREADY; hold_addr = ARADDR; hold_len = ARLEN;
      if (ARREADY) begin
        check("ar_outstanding", 32'(q_addr.size()), 32'd0);
        check("arid", 32'(ARID), 32'(MST_ID));
        check("arsize", 32'(ARSIZE), 32'd2);
        check("arburst", 32'(ARBURST), 32'd1);
        q_addr.push_back(ARADDR); q_len.push_back(ARLEN);
        ar_log_addr.push_back(ARADDR); ar_log_len.push_back(ARLEN);
        ar_wait = 0;
      end else begin
        ar_wait++;
      end
    end else begin
      hold_v = 1'b0;
    end
    if (RVALID && RREADY) begin
      r_taken = 1'b1;
      r_beat++; cmd_beat++;
      if (r_beat > int'(q_len[0])) begin
        void'(q_addr.pop_front()); void'(q_len.pop_front()); r_beat = 0;
      end
    end
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) begin done_cnt++; done_err = err; done_cyc = cyc; end
    if (cmd_valid && cmd_ready) begin pend_valid = 1'b0; acc_cyc = cyc; end
  endtask

  task automatic run_cmd(input string tag, input vec_t v, input logic [31:0] xr);
    logic [31:0] a;
    logic [31:0] eb_addr[$];
    int          eb_len[$];
    int          rem, b, room, n;
    // Reference: greedy burst split and expected word stream
    a = {v.addr[31:2], 2'b00}; rem = int'(v.words);
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 4;
      b = rem; if (b > 16) b = 16; if (b > room) b = room;
      eb_addr.push_back(a); eb_len.push_back(b - 1);
      a = a + 32'(4 * b); rem = rem - b;
    end
    ar_delay = v.ar_delay; ready_pct = v.ready_pct; gap_pct = v.gap_pct;
    resp_bad = v.resp_bad; last_bad = v.last_bad; id_bad = v.id_bad;
    data_base = {v.addr[31:2], 2'b00}; data_xor = xr;
    ar_log_addr.delete(); ar_log_len.delete(); got.delete();
    done_cnt = 0; cmd_beat = 0; first_ar_cyc = -1; acc_cyc = -1; done_cyc = -1;
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    pend_valid = 1'b1; pend_addr = v.addr; pend_words = v.words;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin cycle(); n++; end
    for (int k = 0; k < 3; k++) cycle();
    check("done_once", 32'(done_cnt), 32'd1);
    check("err_at_done", 32'(done_err), 32'(v.exp_err));
    check("err_held", 32'(err), 32'(v.exp_err));
    if (v.words == 16'd0) begin
      check("zero_done_latency", 32'(done_cyc - acc_cyc), 32'd1);
      check("zero_no_ar", 32'(first_ar_cyc), 32'hFFFF_FFFF);
    end else begin
      check("arvalid_latency", 32'(first_ar_cyc - acc_cyc), 32'd1);
    end
    if (v.exp_nb >= 0) check("n_bursts_tbl", 32'(ar_log_addr.size()), 32'(v.exp_nb));
    check("n_bursts", 32'(ar_log_addr.size()), 32'(eb_addr.size()));
    for (int i = 0; i < eb_addr.size() && i < ar_log_addr.size(); i++) begin
      check("burst_addr", ar_log_addr[i], eb_addr[i]);
      check("burst_len", 32'(ar_log_len[i]), 32'(eb_len[i]));
    end
    check("n_words", 32'(got.size()), 32'(v.words));
    for (int i = 0; i < got.size() && i < int'(v.words); i++)
      check("word", got[i], 32'(i) ^ xr);
    $display("cmd %s addr=0x%08h words=%0d bursts=%0d got=%0d err=%0b", tag, v.addr,
             v.words, ar_log_addr.size(), got.size(), done_err);
  endtask

  vec_t tbl[10];
  vec_t v;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_addr = 32'd0; cmd_words = 16'd0; out_ready = 1'b0;
    pend_valid = 1'b0; pend_addr = 32'd0; pend_words = 16'd0;
    cyc = 0; first_ar_cyc = -1; done_cnt = 0; done_err = 1'b0;
    cmd_beat = 0; ar_delay = 0; ready_pct = 100; gap_pct = 0;
    resp_bad = -1; last_bad = -1; id_bad = -1; data_base = 32'd0; data_xor = 32'd0;
    clear_slave();

    //           addr          words rb  lb  ib  ard rdy gap nb err
    tbl[0] = mk(32'h0000_1000,  4,  -1, -1, -1,  0, 100,  0, 1, 1'b0);
    tbl[1] = mk(32'h0000_2000, 40,  -1, -1, -1,  0, 100,  0, 3, 1'b0);
    tbl[2] = mk(32'h0000_0FF8,  6,  -1, -1, -1,  0, 100,  0, 2, 1'b0);
    tbl[3] = mk(32'h0000_3000, 20,  -1, -1, -1,  3,  50,  0, 2, 1'b0);
    tbl[4] = mk(32'h0000_4000,  4,   1, -1, -1,  0, 100,  0, 1, 1'b1);
    tbl[5] = mk(32'h0000_5000,  4,  -1, -1, -1,  0, 100,  0, 1, 1'b0);
    tbl[6] = mk(32'h0000_6000,  4,  -1,  2, -1,  0, 100,  0, 1, 1'b1);
    tbl[7] = mk(32'h0000_7004,  8,  -1, -1,  5,  1,  70, 30, 1, 1'b1);
    tbl[8] = mk(32'h0000_8000,  4,  -1,  3, -1,  0, 100,  0, 1, 1'b1);
    tbl[9] = mk(32'h0000_1FFE,  3,  -1, -1, -1,  0, 100,  0, 2, 1'b0);

    for (int k = 0; k < 3; k++) cycle();
    check("rst_arvalid", 32'(ARVALID), 32'd0);
    check("rst_araddr", ARADDR, 32'd0);
    check("rst_arlen", 32'(ARLEN), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rready", 32'(RREADY), 32'd0);
    @(negedge clk); rst = 1'b1;
    cycle();

    for (int i = 0; i < 10; i++) run_cmd($sformatf("tbl%0d", i), tbl[i], (i == 3) ? 32'd0 : $urandom());

    // Zero-length command as a directed case
    run_cmd("zero", mk(32'h0000_9000, 0, -1, -1, -1, 0, 100, 0, 0, 1'b0), 32'd0);

    for (int i = 0; i < 20; i++) begin
      v.addr = 32'h0001_0000 + (32'($urandom_range(0, 7)) << 12) +
               (($urandom_range(0, 1) == 1) ? 32'(4096 - 4 * $urandom_range(1, 20))
                                            : 32'($urandom_range(0, 4095)));
      v.words = 16'($urandom_range(0, 70));
      v.resp_bad = -1; v.last_bad = -1; v.id_bad = -1;
      v.ar_delay = int'($urandom_range(0, 3));
      v.ready_pct = int'($urandom_range(30, 100));
      v.gap_pct = int'($urandom_range(0, 60));
      v.exp_nb = -1; v.exp_err = 1'b0;
      run_cmd($sformatf("rnd%0d", i), v, $urandom());
    end

    // Asynchronous reset while a second burst address is waiting for ARREADY
    v = mk(32'h0000_A000, 40, -1, -1, -1, 4, 100, 0, -1, 1'b0);
    ar_delay = 4; ready_pct = 100; gap_pct = 0; resp_bad = -1; last_bad = -1; id_bad = -1;
    data_base = v.addr; data_xor = 32'd0;
    ar_log_addr.delete(); ar_log_len.delete(); got.delete(); cmd_beat = 0;
    pend_valid = 1'b1; pend_addr = v.addr; pend_words = v.words;
    for (int n = 0; n < 500 && !(ar_log_addr.size() == 1 && ARVALID); n++) cycle();
    check("prerst_arvalid", 32'(ARVALID), 32'd1);
    check("prerst_cmd_ready", 32'(cmd_ready), 32'd0);
    #1 rst = 1'b0;
    #1;
    check("async_rst_arvalid", 32'(ARVALID), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("async_rst_rready", 32'(RREADY), 32'd0);
    $display("reset mid-burst: arvalid=%0b cmd_ready=%0b", ARVALID, cmd_ready);
    pend_valid = 1'b0;
    clear_slave();
    for (int k = 0; k < 2; k++) cycle();
    @(negedge clk); rst = 1'b1;
    cycle();
    run_cmd("post_rst", mk(32'h0000_B000, 5, -1, -1, -1, 0, 100, 0, 1, 1'b0), $urandom());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
